// File: rtl/vehicle_call_conditioner.sv
// vehicle_call_conditioner
//   Front end for the two-street traffic light controller. Each raw loop
//   detector is synchronized, debounced and latched into a vehicle call
//   (Sa/Sb). A call is cleared once its street is seen green with an empty
//   detector. Stuck detectors and conflicting greens fail safe by forcing
//   the affected calls permanently on.
// Ports:
//   clk      rising-edge system clock
//   reset_n  synchronous active-low reset
//   det_a/b  raw asynchronous detector inputs (1 = vehicle present)
//   Ga/Gb    street greens from the controller (synchronous)
//   Sa/Sb    registered street calls
//   fault_a/b  sticky stuck-detector flags
//   conflict sticky flag: Ga and Gb seen high together

// One detector channel: 2-flop sync, debounce, presence watchdog, call latch.
module vcc_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int MAX_PRESENCE    = 200,
  parameter int PRES_W          = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_det,
  input  logic i_green,
  input  logic i_force,   // next-state of the shared conflict flag
  output logic o_call,
  output logic o_fault
);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(MAX_PRESENCE - 1);

  logic [1:0]        r_sync;
  logic              r_filt;
  logic [CNT_W-1:0]  r_cnt;
  logic [PRES_W-1:0] r_pres;
  logic              r_call;
  logic              r_fault;
  logic              w_sync;
  logic              w_fault_nxt;

  assign w_sync = r_sync[1];
  // Fault is folded into the call on the same edge it asserts.
  assign w_fault_nxt = r_fault | (r_filt & (r_pres == PRES_LAST));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
      r_pres  <= '0;
      r_call  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_det};

      // Filtered level follows only after DEBOUNCE_CYCLES consecutive
      // disagreeing samples; any agreeing sample restarts the count.
      if (w_sync != r_filt) begin
        if (r_cnt == DB_LAST) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end

      if (!r_filt)           r_pres <= '0;
      else if (r_pres != '1) r_pres <= r_pres + 1'b1;

      r_fault <= w_fault_nxt;

      // Set (waiting, red) and clear (served, empty) cannot both be true.
      if (w_fault_nxt | i_force)  r_call <= 1'b1;
      else if (r_filt & ~i_green) r_call <= 1'b1;
      else if (i_green & ~r_filt) r_call <= 1'b0;
    end
  end

  assign o_call  = r_call;
  assign o_fault = r_fault;
endmodule

module vehicle_call_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int MAX_PRESENCE    = 200,
  parameter int PRES_W          = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic det_a,
  input  logic det_b,
  input  logic Ga,
  input  logic Gb,
  output logic Sa,
  output logic Sb,
  output logic fault_a,
  output logic fault_b,
  output logic conflict
);
  localparam int NUM_CH = 2;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (MAX_PRESENCE < 1 || MAX_PRESENCE > (1 << PRES_W) - 1) begin : g_bad_pres
    $error("MAX_PRESENCE out of range for PRES_W");
  end

  logic              r_conflict;
  logic              w_conf_nxt;
  logic [NUM_CH-1:0] w_det, w_green, w_call, w_fault;

  assign w_det      = {det_b, det_a};
  assign w_green    = {Gb, Ga};
  assign w_conf_nxt = r_conflict | (Ga & Gb);

  always_ff @(posedge clk) begin
    if (!reset_n) r_conflict <= 1'b0;
    else          r_conflict <= w_conf_nxt;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vcc_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .MAX_PRESENCE   (MAX_PRESENCE),
      .PRES_W         (PRES_W)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .i_det  (w_det[c]),
      .i_green(w_green[c]),
      .i_force(w_conf_nxt),
      .o_call (w_call[c]),
      .o_fault(w_fault[c])
    );
  end

  assign Sa       = w_call[0];
  assign Sb       = w_call[1];
  assign fault_a  = w_fault[0];
  assign fault_b  = w_fault[1];
  assign conflict = r_conflict;
endmodule

// File: tb/tb_vehicle_call_conditioner.sv
module tb_vehicle_call_conditioner;
  localparam int DB   = 4;
  localparam int MAXP = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic det_a = 1'b0, det_b = 1'b0, Ga = 1'b0, Gb = 1'b0;
  logic Sa, Sb, fault_a, fault_b, conflict;

  int n_cmp = 0;
  int n_bad = 0;

  vehicle_call_conditioner #(
    .DEBOUNCE_CYCLES(DB), .CNT_W(3), .MAX_PRESENCE(MAXP), .PRES_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .det_a(det_a), .det_b(det_b),
    .Ga(Ga), .Gb(Gb), .Sa(Sa), .Sb(Sb),
    .fault_a(fault_a), .fault_b(fault_b), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Reference model: the detector value seen by the debouncer is the raw
  // value two edges back; the filtered level flips when the last DB such
  // samples all disagree with it; a stuck fault is a run of MAXP edges
  // with the filtered level high.
  bit       s1m[2], s2m[2], filtm[2], callm[2], faultm[2], confm, mvalid;
  int       runm[2];
  bit [31:0] hist[2];

  always @(posedge clk) begin
    bit g[2], d[2], old, nf, cn, allx;
    g[0] = Ga;    g[1] = Gb;
    d[0] = det_a; d[1] = det_b;
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        s1m[c] = 0; s2m[c] = 0; filtm[c] = 0; callm[c] = 0;
        faultm[c] = 0; runm[c] = 0; hist[c] = '0;
      end
      confm  = 0;
      mvalid = 1;
    end else begin
      cn = confm | (Ga & Gb);
      for (int c = 0; c < 2; c++) begin
        old = filtm[c];
        hist[c] = {hist[c][30:0], s2m[c]};
        allx = 1;
        for (int i = 0; i < DB; i++) if (hist[c][i] == old) allx = 0;
        runm[c] = old ? runm[c] + 1 : 0;
        nf = faultm[c] | (runm[c] >= MAXP);
        if (nf | cn)         callm[c] = 1;
        else if (old & !g[c]) callm[c] = 1;
        else if (g[c] & !old) callm[c] = 0;
        faultm[c] = nf;
        if (allx) filtm[c] = s2m[c];
        s2m[c] = s1m[c];
        s1m[c] = d[c];
      end
      confm = cn;
    end
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("Sa",       Sa,       callm[0]);
      chk("Sb",       Sb,       callm[1]);
      chk("fault_a",  fault_a,  faultm[0]);
      chk("fault_b",  fault_b,  faultm[1]);
      chk("conflict", conflict, confm);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_Sa"}, Sa, 1'b0);
    chk({tag, "_Sb"}, Sb, 1'b0);
    chk({tag, "_fa"}, fault_a, 1'b0);
    chk({tag, "_fb"}, fault_b, 1'b0);
    chk({tag, "_cf"}, conflict, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then idle with street A green.
    reset_n = 0;
    tick(2);
    chk_all0("rst");
    reset_n = 1; Ga = 1;
    tick(20);
    chk_all0("idle");

    // 3-cycle glitch on B is rejected.
    Ga = 0;
    det_b = 1; tick(3);
    det_b = 0; tick(10);
    chk("glitch_Sb", Sb, 1'b0);

    // Steady B presence: call at edge 3+DB, not before.
    det_b = 1;
    tick(2 + DB);
    chk("lat6_Sb", Sb, 1'b0);
    tick(1);
    chk("lat7_Sb", Sb, 1'b1);

    // Call stays latched through red after the vehicle leaves.
    det_b = 0;
    tick(30);
    chk("hold_Sb", Sb, 1'b1);
    Gb = 1;
    tick(1);
    chk("served_Sb", Sb, 1'b0);

    // Green extension: call held while presence continues on green.
    Gb = 0; det_b = 1;
    tick(10);
    chk("recall_Sb", Sb, 1'b1);
    Gb = 1;
    tick(5);
    chk("ext_Sb", Sb, 1'b1);
    det_b = 0;
    tick(2 + DB);
    chk("ext6_Sb", Sb, 1'b1);
    tick(1);
    chk("ext7_Sb", Sb, 1'b0);
    Gb = 0;
    tick(3);

    // Stuck A detector while A green: fault exactly MAXP edges after filt rose.
    Ga = 1; det_a = 1;
    tick(2 + DB + MAXP - 1);
    chk("stk_pre_fa", fault_a, 1'b0);
    chk("stk_pre_Sa", Sa, 1'b0);
    tick(1);
    chk("stk_fa", fault_a, 1'b1);
    chk("stk_Sa", Sa, 1'b1);
    det_a = 0;
    tick(20);
    chk("stk_hold_fa", fault_a, 1'b1);
    chk("stk_hold_Sa", Sa, 1'b1);

    // Conflicting greens for one cycle.
    Gb = 1;
    tick(1);
    chk("cf", conflict, 1'b1);
    chk("cf_Sa", Sa, 1'b1);
    chk("cf_Sb", Sb, 1'b1);
    Gb = 0;
    tick(5);
    chk("cf_hold", conflict, 1'b1);
    chk("cf_hold_Sb", Sb, 1'b1);

    // Mid-run reset with det_b held high.
    Ga = 0; det_b = 1;
    tick(10);
    reset_n = 0;
    tick(1);
    chk_all0("mrst");
    reset_n = 1;
    tick(2 + DB);
    chk("mrst6_Sb", Sb, 1'b0);
    tick(1);
    chk("mrst7_Sb", Sb, 1'b1);
    chk("mrst7_fa", fault_a, 1'b0);
    chk("mrst7_cf", conflict, 1'b0);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vehicle_call_conditioner.md
Name: vehicle_call_conditioner

Overview:
- Front end that produces the street service requests Sa/Sb for the two-street traffic light controller.
- Takes raw, asynchronous loop-detector inputs for street A and street B, then synchronizes, debounces and latches them into vehicle calls.
- Clears each call once the controller is observed serving that street (its green is on and the detector is empty).
- Detects stuck detectors and conflicting greens, and fails safe.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized input must differ from its filtered level before the filtered level follows; range 1..2^CNT_W-1
CNT_W, 3, debounce counter width
MAX_PRESENCE, 200, continuous filtered-presence cycles that declare a detector stuck; range 1..2^PRES_W-1
PRES_W, 8, presence counter width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset, synchronous, active-low
det_a  input  1  raw street-A detector, asynchronous to clk, 1 = vehicle present
det_b  input  1  raw street-B detector, asynchronous to clk, 1 = vehicle present
Ga  input  1  street-A green from the controller
Gb  input  1  street-B green from the controller
Sa  output  1  registered street-A call to the controller
Sb  output  1  registered street-B call to the controller
fault_a  output  1  street-A detector stuck, sticky
fault_b  output  1  street-B detector stuck, sticky
conflict  output  1  Ga and Gb were high in the same cycle, sticky

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low: reset_n sampled low at a rising edge clears all state. Ga/Gb are synchronous to clk.
- Reset values: Sa, Sb, fault_a, fault_b, conflict all 0. Sync flops, filtered levels, debounce counters and presence counters all 0.
- Reset mid-operation: state clears on that edge, with no residual call or fault. Debouncing restarts from filtered = 0.
- Each channel x in {a, b} is independent and identical.
- Synchronizer: two flops per det_x, producing sync_x.
- Debounce:
  - On each edge where sync_x != filt_x, increment cnt_x.
  - On the edge where cnt_x == DEBOUNCE_CYCLES-1 and they still differ, set filt_x <= sync_x and cnt_x <= 0.
  - Any edge with sync_x == filt_x sets cnt_x <= 0. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Latency: det_x stable from before edge 1 gives sync_x at edge 2, filt_x at edge 2+DEBOUNCE_CYCLES, and Sx at edge 3+DEBOUNCE_CYCLES (edge 7 for default). Falling presence has the same latency.
- Call latch (next-state of Sx):
  - Set when filt_x = 1 and Gx = 0 (waiting vehicle).
  - Clear when Gx = 1 and filt_x = 0 (street served, no more traffic).
  - Otherwise hold. This means Sx stays 1 during green while presence continues (green extension), and a call arriving and leaving during red stays latched until served.
  - Set and clear conditions are mutually exclusive by construction.
- Stuck detection:
  - pres_x increments (saturating) on each edge with filt_x = 1 and clears when filt_x = 0.
  - On the edge where pres_x == MAX_PRESENCE-1 and filt_x = 1, fault_x <= 1.
  - fault_x is sticky until reset. While fault_x = 1, Sx is forced to 1 (permanent recall), overriding the latch.
- Conflict: any edge with Ga = 1 and Gb = 1 sets conflict <= 1, sticky until reset. When conflict = 1, both Sa and Sb are forced to 1. Calls are unaffected otherwise.
- All outputs are registered; there is no combinational path from any input to any output.
- Parameter ranges are checked only in simulation (assertion on elaboration).

Test Plan:
- Reset, det_a = det_b = 0, Ga = 1, Gb = 0 for 20 cycles -> Sa = Sb = fault_a = fault_b = conflict = 0 throughout.
- det_b = 1 for 3 cycles, then 0, Gb = 0 -> Sb stays 0. det_b = 1 held from before edge 1 -> Sb = 1 first at edge 7, not at edge 6.
- Sb latched, det_b drops, Gb = 0 for 30 cycles -> Sb stays 1. Then Gb = 1 with filt_b = 0 -> Sb = 0 one edge later. Repeat with det_b held high during Gb = 1 -> Sb stays 1 until det_b has been low for DEBOUNCE_CYCLES cycles plus sync latency.
- det_a held 1 with Ga = 1 and MAX_PRESENCE = 200 -> fault_a = 1 exactly 200 edges after filt_a rose. Then det_a = 0 and Ga = 1 -> Sa stays 1 and fault_a stays 1.
- Ga = Gb = 1 for one cycle -> conflict = 1 next edge, Sa = Sb = 1, held after greens return legal.
- Sb = 1 and fault_a = 1, then reset_n low for one edge -> all outputs 0 after that edge. With det_b still high, Sb returns 1 at edge 3+DEBOUNCE_CYCLES after reset release.
